// File: rtl/sgb_mem_arbiter.sv
// sgb_mem_arbiter
//   Shares one 16-bit external memory port (SDRAM controller side) between the
//   SNES cartridge ROM fetch path (word reads) and the Game Boy cartridge bus
//   (byte reads of GB ROM, byte writes of GB cart RAM). SNES has fixed
//   priority unless a GB request has waited MAX_WAIT cycles or more. Only one
//   memory transaction is outstanding at a time.
//
//   Optional build macro: SGB_ARB_GB_CACHE_EN adds a one-word GB read cache
//   so that repeated GB reads of the same word skip the memory port.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   snes_req/snes_addr    SNES word-read pulse and 24-bit word address
//   snes_q/snes_valid     SNES read data and its 1-cycle valid pulse
//   gb_rd/gb_wr           GB byte read / byte write pulses
//   gb_addr/gb_wdata      GB 23-bit byte address and write byte
//   gb_q/gb_done          GB read byte and 1-cycle done pulse (reads and writes)
//   mem_req..mem_be       memory request (level, held until mem_ack) and fields
//   mem_ack/mem_q         memory completion pulse and read data

module sgb_mem_arbiter #(
    parameter logic [23:0] GB_ROM_BASE = 24'h400000,
    parameter logic [23:0] GB_RAM_BASE = 24'h7E0000,
    parameter int          MAX_WAIT    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snes_req,
    input  logic [23:0] snes_addr,
    output logic [15:0] snes_q,
    output logic        snes_valid,
    input  logic        gb_rd,
    input  logic        gb_wr,
    input  logic [22:0] gb_addr,
    input  logic [7:0]  gb_wdata,
    output logic [7:0]  gb_q,
    output logic        gb_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    input  logic        mem_ack,
    input  logic [15:0] mem_q
);

    localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, SNES, GB} state_t;

    state_t state, state_nx;

    // Pending request holding registers
    logic        snes_pend;
    logic [23:0] snes_addr_r;
    logic        gb_pend;
    logic [22:0] gb_addr_r;
    logic [7:0]  gb_wdata_r;
    logic        gb_we_r;
    logic [7:0]  gb_wait;

    // Attributes of the GB transaction in flight; the pending fields may be
    // overwritten by a new pulse while it is outstanding.
    logic        cur_we;
    logic        cur_lsb;
    logic [21:0] cur_tag;

    logic        grant_snes, grant_gb;
    logic        snes_ack, gb_ack;
    logic        cache_hit;
    logic [7:0]  hit_byte;
    logic        gb_pulse;
    logic [23:0] gb_rom_addr, gb_ram_addr;

    assign snes_ack = (state == SNES) && mem_ack;
    assign gb_ack   = (state == GB) && mem_ack;

    // Address arithmetic wraps modulo 2^24
    assign gb_rom_addr = GB_ROM_BASE + {2'b00, gb_addr_r[22:1]};
    assign gb_ram_addr = GB_RAM_BASE + {8'h00, gb_addr_r[16:1]};

`ifdef SGB_ARB_GB_CACHE_EN
    logic        cache_vld;
    logic [21:0] cache_tag;
    logic [15:0] cache_data;

    // A hit colliding with a GB completion is treated as a miss so that the
    // single gb_q/gb_done slot is never claimed twice in one cycle.
    assign cache_hit = gb_rd && !gb_wr && cache_vld && !gb_ack &&
                       (cache_tag == gb_addr[22:1]);
    assign hit_byte  = gb_addr[0] ? cache_data[15:8] : cache_data[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld  <= 1'b0;
            cache_tag  <= '0;
            cache_data <= '0;
        end else if (gb_wr || (gb_ack && cur_we)) begin
            cache_vld <= 1'b0;
        end else if (gb_ack && !(gb_pend && gb_we_r)) begin
            // Skip the fill if a write is already queued behind this read
            cache_vld  <= 1'b1;
            cache_tag  <= cur_tag;
            cache_data <= mem_q;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_byte  = 8'h00;
`endif

    assign gb_pulse = (gb_rd || gb_wr) && !cache_hit;

    // Grant decision and state sequencing
    always_comb begin
        state_nx   = state;
        grant_snes = 1'b0;
        grant_gb   = 1'b0;
        case (state)
            IDLE: begin
                if (snes_pend && gb_pend) begin
                    if (gb_wait < MAX_WAIT_W) grant_snes = 1'b1;
                    else                      grant_gb   = 1'b1;
                end else if (snes_pend) begin
                    grant_snes = 1'b1;
                end else if (gb_pend) begin
                    grant_gb = 1'b1;
                end
                if (grant_snes)    state_nx = SNES;
                else if (grant_gb) state_nx = GB;
            end
            SNES:    if (mem_ack) state_nx = IDLE;
            GB:      if (mem_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snes_pend   <= 1'b0;
            snes_addr_r <= '0;
            gb_pend     <= 1'b0;
            gb_addr_r   <= '0;
            gb_wdata_r  <= '0;
            gb_we_r     <= 1'b0;
            gb_wait     <= '0;
            cur_we      <= 1'b0;
            cur_lsb     <= 1'b0;
            cur_tag     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            snes_q      <= '0;
            snes_valid  <= 1'b0;
            gb_q        <= '0;
            gb_done     <= 1'b0;
        end else begin
            // A new pulse wins over the grant-cycle clear, so a request for
            // the transaction being launched is kept as a fresh pending one.
            if (snes_req) begin
                snes_pend   <= 1'b1;
                snes_addr_r <= snes_addr;
            end else if (grant_snes) begin
                snes_pend <= 1'b0;
            end

            if (gb_pulse) begin
                gb_pend    <= 1'b1;
                gb_addr_r  <= gb_addr;
                gb_wdata_r <= gb_wdata;
                gb_we_r    <= gb_wr;
            end else if (grant_gb) begin
                gb_pend <= 1'b0;
            end

            if (grant_gb)                       gb_wait <= '0;
            else if (gb_pend && gb_wait != 8'hFF) gb_wait <= gb_wait + 8'd1;

            // Memory fields load only at grant, so they stay put while mem_req=1
            if (grant_snes) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= snes_addr_r;
                mem_wdata <= '0;
                mem_be    <= 2'b11;
            end else if (grant_gb) begin
                mem_req   <= 1'b1;
                mem_we    <= gb_we_r;
                mem_addr  <= gb_we_r ? gb_ram_addr : gb_rom_addr;
                mem_wdata <= gb_we_r ? {gb_wdata_r, gb_wdata_r} : 16'h0000;
                mem_be    <= !gb_we_r ? 2'b11 : (gb_addr_r[0] ? 2'b10 : 2'b01);
                cur_we    <= gb_we_r;
                cur_lsb   <= gb_addr_r[0];
                cur_tag   <= gb_addr_r[22:1];
            end else if (mem_ack && state != IDLE) begin
                mem_req <= 1'b0;
            end

            snes_valid <= snes_ack;
            if (snes_ack) snes_q <= mem_q;

            gb_done <= gb_ack || cache_hit;
            if (gb_ack && !cur_we) gb_q <= cur_lsb ? mem_q[15:8] : mem_q[7:0];
            else if (cache_hit)    gb_q <= hit_byte;
        end
    end

endmodule

// File: tb/tb_sgb_mem_arbiter.sv
// Directed self-checking bench for sgb_mem_arbiter. A small memory responder
// acks requests after a programmable delay and logs every completed
// transaction; monitors count snes_valid / gb_done pulses and their order.

module tb_sgb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snes_req = 1'b0;
    logic [23:0] snes_addr = '0;
    logic [15:0] snes_q;
    logic        snes_valid;
    logic        gb_rd = 1'b0;
    logic        gb_wr = 1'b0;
    logic [22:0] gb_addr = '0;
    logic [7:0]  gb_wdata = '0;
    logic [7:0]  gb_q;
    logic        gb_done;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        rsp_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic        mem_ack;
    logic [15:0] mem_q = '0;

    assign mem_ack = rsp_ack | stray_ack;

    sgb_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .snes_req(snes_req), .snes_addr(snes_addr), .snes_q(snes_q), .snes_valid(snes_valid),
        .gb_rd(gb_rd), .gb_wr(gb_wr), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
        .gb_q(gb_q), .gb_done(gb_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Responder state
    bit          rsp_en = 1'b1;
    int          ack_dly = 0;
    logic [15:0] rsp_data = '0;
    int          unstable = 0;
    logic [23:0] lg_addr[$];
    logic        lg_we[$];
    logic [15:0] lg_wd[$];
    logic [1:0]  lg_be[$];

    initial begin
        int cnt;
        logic [42:0] snap;
        cnt = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (rsp_ack) begin
                rsp_ack = 1'b0;
                cnt = 0;
            end else if (mem_req && rsp_en) begin
                if (cnt == 0) snap = {mem_we, mem_addr, mem_wdata, mem_be};
                else if (snap !== {mem_we, mem_addr, mem_wdata, mem_be}) unstable++;
                if (cnt == ack_dly) begin
                    rsp_ack = 1'b1;
                    mem_q = rsp_data;
                    lg_addr.push_back(mem_addr);
                    lg_we.push_back(mem_we);
                    lg_wd.push_back(mem_wdata);
                    lg_be.push_back(mem_be);
                end else begin
                    cnt++;
                end
            end else if (!mem_req) begin
                cnt = 0;
            end
        end
    end

    // Output monitors
    int          snes_cnt = 0, gb_cnt = 0, evt = 0;
    int          snes_cyc = 0, gb_cyc = 0, snes_seq = 0, gb_seq = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (snes_valid) begin
                snes_cnt++; snes_cyc = cyc; evt++; snes_seq = evt;
            end
            if (gb_done) begin
                gb_cnt++; gb_cyc = cyc; evt++; gb_seq = evt;
            end
        end
    end

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_evt(input bit gb, input int n);
        for (int i = 0; i < 100; i++) begin
            if ((gb ? gb_cnt : snes_cnt) >= n) break;
            nclk();
        end
        chk(gb ? "wait_gb" : "wait_snes", gb ? gb_cnt : snes_cnt, n);
    endtask

    initial begin
        int t0, base, ns, ng;

        // Reset state
        repeat (3) nclk();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_snes_valid", snes_valid, 0);
        chk("rst_gb_done", gb_done, 0);
        chk("rst_snes_q", snes_q, 0);
        chk("rst_gb_q", gb_q, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        rst_n = 1'b1;
        nclk();

        // Single SNES read, ack 2 cycles after mem_req
        ack_dly = 2; rsp_data = 16'hBEEF;
        base = lg_addr.size();
        snes_addr = 24'h001234; snes_req = 1'b1; t0 = cyc;
        nclk(); snes_req = 1'b0;
        wait_evt(0, 1);
        chk("snes_lat", snes_cyc - t0, 5);
        chk("snes_addr", lg_addr[base], 24'h001234);
        chk("snes_we", lg_we[base], 0);
        chk("snes_be", lg_be[base], 2'b11);
        chk("snes_q", snes_q, 16'hBEEF);
        repeat (4) nclk();
        chk("snes_one_pulse", snes_cnt, 1);

        // GB read, high byte, same-cycle ack -> 3-cycle latency
        ack_dly = 0; rsp_data = 16'hA55A;
        base = lg_addr.size();
        gb_addr = 23'h000101; gb_rd = 1'b1; t0 = cyc;
        nclk(); gb_rd = 1'b0;
        wait_evt(1, 1);
        chk("gbrd_lat", gb_cyc - t0, 3);
        chk("gbrd_addr", lg_addr[base], 24'h400080);
        chk("gbrd_we", lg_we[base], 0);
        chk("gbrd_q", gb_q, 8'hA5);
        repeat (4) nclk();
        chk("gbrd_one_pulse", gb_cnt, 1);

        // Same word, low byte: cache hit when enabled, memory otherwise
        base = lg_addr.size();
        gb_addr = 23'h000100; gb_rd = 1'b1; t0 = cyc;
        nclk(); gb_rd = 1'b0;
        wait_evt(1, 2);
        chk("gbrd2_q", gb_q, 8'h5A);
`ifdef SGB_ARB_GB_CACHE_EN
        chk("gbhit_lat", gb_cyc - t0, 1);
        chk("gbhit_no_mem", lg_addr.size() - base, 0);
`else
        chk("gbrd2_lat", gb_cyc - t0, 3);
        chk("gbrd2_addr", lg_addr[base], 24'h400080);
`endif
        repeat (3) nclk();

        // GB write to odd byte
        base = lg_addr.size();
        gb_addr = 23'h000003; gb_wdata = 8'h3C; gb_wr = 1'b1;
        nclk(); gb_wr = 1'b0;
        wait_evt(1, 3);
        chk("gbwr_addr", lg_addr[base], 24'h7E0001);
        chk("gbwr_we", lg_we[base], 1);
        chk("gbwr_wdata", lg_wd[base], 16'h3C3C);
        chk("gbwr_be", lg_be[base], 2'b10);
        chk("gbwr_q_held", gb_q, 8'h5A);
        repeat (3) nclk();

        // Read after write must reach memory (cache invalidated by the write)
        rsp_data = 16'h1234;
        base = lg_addr.size();
        gb_addr = 23'h000100; gb_rd = 1'b1;
        nclk(); gb_rd = 1'b0;
        wait_evt(1, 4);
        chk("gbrd3_mem", lg_addr.size() - base, 1);
        chk("gbrd3_q", gb_q, 8'h34);
        repeat (3) nclk();

        // Simultaneous SNES and GB requests, gb_wait=0 -> SNES first
        ack_dly = 1; rsp_data = 16'hC0DE;
        base = lg_addr.size();
        snes_addr = 24'h000010; snes_req = 1'b1;
        gb_addr = 23'h000020; gb_rd = 1'b1;
        nclk(); snes_req = 1'b0; gb_rd = 1'b0;
        wait_evt(0, 2);
        wait_evt(1, 5);
        chk("sim_first", lg_addr[base], 24'h000010);
        chk("sim_second", lg_addr[base+1], 24'h400010);
        chk("sim_order", gb_seq > snes_seq, 1);
        chk("sim_snes_q", snes_q, 16'hC0DE);
        chk("sim_gb_q", gb_q, 8'hDE);
        repeat (3) nclk();

        // Starvation: SNES requesting continuously, GB pending -> third grant is GB
        ack_dly = 3;
        base = lg_addr.size();
        ns = snes_cnt; ng = gb_cnt;
        snes_addr = 24'h000077; snes_req = 1'b1;
        gb_addr = 23'h000040; gb_rd = 1'b1;
        nclk(); gb_rd = 1'b0;
        repeat (14) nclk();
        snes_req = 1'b0;
        wait_evt(1, ng + 1);
        repeat (12) nclk();
        chk("starve_g0", lg_addr[base], 24'h000077);
        chk("starve_g1", lg_addr[base+1], 24'h000077);
        chk("starve_g2", lg_addr[base+2], 24'h400020);
        chk("starve_snes_done", snes_cnt > ns + 1, 1);

        // Reset with mem_req=1, then a stray ack
        rsp_en = 1'b0;
        ns = snes_cnt; ng = gb_cnt;
        snes_addr = 24'h000500; snes_req = 1'b1;
        nclk(); snes_req = 1'b0;
        for (int i = 0; i < 20 && !mem_req; i++) nclk();
        chk("rst_mid_req_up", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req_drop", mem_req, 0);
        nclk(); nclk();
        rst_n = 1'b1;
        nclk();
        stray_ack = 1'b1;
        nclk(); stray_ack = 1'b0;
        repeat (6) nclk();
        chk("stray_snes", snes_cnt, ns);
        chk("stray_gb", gb_cnt, ng);
        chk("no_retry", mem_req, 0);
        rsp_en = 1'b1;

        chk("mem_stable", unstable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
